mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port data RAM between two requesters: the CPU10Bits memory stage and a DMA/loader port used for program/data load and debug readback.
- Sits between the EtoM pipeline register outputs and the RAM.
- Grants one access per cycle and stalls the CPU when the DMA port wins.
- CPU has priority; a starvation counter and a bounded DMA burst guarantee forward progress for both requesters.

Parameters:
DW, 10, data width
AW, 10, address width
BURST_MAX, 4, maximum consecutive DMA grants while the CPU is waiting (>=1)
STARVE_MAX, 8, consecutive denied DMA-request cycles before DMA is forced in (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
cpu_req  input  1  CPU memory-stage access request
cpu_we  input  1  1=store, 0=load
cpu_addr  input  AW  CPU address
cpu_wdata  input  DW  CPU store data
cpu_stall  output  1  CPU request not granted this cycle; pipeline holds
cpu_rvalid  output  1  CPU load data valid
cpu_rdata  output  DW  CPU load data; 0 when cpu_rvalid=0
dma_req  input  1  DMA access request; held until dma_gnt
dma_we  input  1  1=store, 0=load
dma_addr  input  AW  DMA address
dma_wdata  input  DW  DMA store data
dma_gnt  output  1  DMA access issued this cycle
dma_rvalid  output  1  DMA load data valid
dma_rdata  output  DW  DMA load data; 0 when dma_rvalid=0
ram_ldst  output  2  RAM command: 00 idle, 01 load, 10 store
ram_addr  output  AW  RAM address; 0 when idle
ram_wdata  output  DW  RAM write data; 0 unless store
ram_rdata  input  DW  RAM read data, valid the cycle after a load

Behaviour:
State and counters:
- Owner state is S_CPU or S_DMA.
- burst_cnt: 0..BURST_MAX.
- starve_cnt: 0..STARVE_MAX, saturating.
- rd_tag: valid bit plus owner bit.

Grant timing:
- Grant is decided combinationally from the registered state and the current requests.
- The granted access drives ram_* in the same cycle.
- cpu_stall = cpu_req & ~cpu_grant.
- dma_gnt = dma_grant.

S_CPU:
- cpu_req & starve_cnt<STARVE_MAX: grant CPU.
- Else if dma_req: grant DMA, go to S_DMA, burst_cnt<=1.
- Else: idle.

S_DMA:
- dma_req & burst_cnt<BURST_MAX: grant DMA, burst_cnt++.
- Else if cpu_req: grant CPU, go to S_CPU, burst_cnt<=0.
- Else if dma_req (burst exhausted, CPU idle): grant DMA, burst_cnt<=1, stay in S_DMA.
- Else: go to S_CPU, burst_cnt<=0.

starve_cnt:
- Increments (saturating) each cycle dma_req=1 and dma_gnt=0.
- Clears on dma_gnt or dma_req=0.

Read tagging:
- On any granted load, rd_tag<=(1, owner); otherwise rd_tag.valid<=0.
- The next cycle, the tagged owner's rvalid=1 and its rdata=ram_rdata.
- cpu_rvalid and dma_rvalid are never both 1.
- Back-to-back loads from different owners return in issue order, one per cycle.

Other rules:
- Stores produce no rvalid.
- Exactly one of cpu_grant/dma_grant/idle per cycle; ram_ldst never 11.

Reset (reset=0, asynchronous, including mid-burst):
- State<=S_CPU; burst_cnt, starve_cnt, rd_tag<=0.
- cpu_rvalid=dma_rvalid=0 and rdata=0 immediately, even if RAM returns data for a load issued before reset.
- Requests present during reset are ignored, with ram_ldst=00.

Test Plan:
- Reset: pulse reset=0 during an outstanding DMA load -> dma_rvalid=0, ram_ldst=00; after release, cpu load grants with no wait cycle.
- CPU only: cpu load addr 0x005, RAM holds 0x2A3 -> cycle 0: ram_ldst=01, ram_addr=0x005, cpu_stall=0; cycle 1: cpu_rvalid=1, cpu_rdata=0x2A3.
- Contention, both requesting continuously (defaults) -> CPU granted cycles 0-7; cycles 8-11: dma_gnt=1, cpu_stall=1; cycle 12: CPU granted; pattern repeats.
- DMA-only stream of 6 stores to 0x100-0x105, cpu_req=0 -> 6 consecutive dma_gnt, no gap; RAM contents verified by later loads.
- Interleaved reads: CPU load 0x010 at cycle n, forced DMA load 0x020 at n+1 -> cpu_rvalid only at n+1, dma_rvalid only at n+2, correct data each.
- Burst cut: DMA in burst, dma_req drops after 2 grants while cpu_req=1 -> CPU granted the next cycle, state S_CPU, starve_cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ==== mem_port_arbiter_if : CPU, DMA and RAM bus bundle for mem_port_arbiter ==== rev 1.0 ====
interface mem_port_arbiter_if #(
   parameter int DW = 10,
   parameter int AW = 10
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_stall;
   logic          cpu_rvalid;
   logic [DW-1:0] cpu_rdata;

   logic          dma_req;
   logic          dma_we;
   logic [AW-1:0] dma_addr;
   logic [DW-1:0] dma_wdata;
   logic          dma_gnt;
   logic          dma_rvalid;
   logic [DW-1:0] dma_rdata;

   logic [1:0]    ram_ldst;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_stall, cpu_rvalid, cpu_rdata,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_gnt, dma_rvalid, dma_rdata,
      output ram_ldst, ram_addr, ram_wdata,
      input  ram_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_stall, cpu_rvalid, cpu_rdata,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_gnt, dma_rvalid, dma_rdata,
      input  ram_ldst, ram_addr, ram_wdata,
      output ram_rdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ==== mem_port_arbiter : CPU-priority arbiter for a single-port data RAM with ====
// ==== DMA starvation guard and bounded DMA bursts                 rev 1.0 ====
module mem_port_arbiter #(
   parameter int DW         = 10,
   parameter int AW         = 10,
   parameter int BURST_MAX  = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);
   localparam int BW = $clog2(BURST_MAX + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [BW-1:0] C_BURST_MAX  = BW'(BURST_MAX);
   localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_MAX);
   localparam logic [1:0]    C_IDLE  = 2'b00;
   localparam logic [1:0]    C_LOAD  = 2'b01;
   localparam logic [1:0]    C_STORE = 2'b10;

   typedef enum logic [0:0] {S_CPU = 1'b0, S_DMA = 1'b1} state_t;

   state_t        r_state, w_state_nxt;
   logic [BW-1:0] r_burst_cnt, w_burst_nxt;
   logic [SW-1:0] r_starve_cnt, w_starve_nxt;
   logic          r_tag_valid, r_tag_dma;
   logic          w_cpu_grant, w_dma_grant;
   logic          w_cpu_issue, w_dma_issue;

   always_comb begin
      w_state_nxt = r_state;
      w_burst_nxt = r_burst_cnt;
      w_cpu_grant = 1'b0;
      w_dma_grant = 1'b0;
      case (r_state)
         S_CPU: begin
            if (bus.cpu_req && (r_starve_cnt < C_STARVE_MAX)) begin
               w_cpu_grant = 1'b1;
            end else if (bus.dma_req) begin
               w_dma_grant = 1'b1;
               w_state_nxt = S_DMA;
               w_burst_nxt = BW'(1);
            end
         end
         S_DMA: begin
            if (bus.dma_req && (r_burst_cnt < C_BURST_MAX)) begin
               w_dma_grant = 1'b1;
               w_burst_nxt = r_burst_cnt + 1'b1;
            end else if (bus.cpu_req) begin
               w_cpu_grant = 1'b1;
               w_state_nxt = S_CPU;
               w_burst_nxt = '0;
            end else if (bus.dma_req) begin
               // burst exhausted but the CPU is idle: start a fresh burst
               w_dma_grant = 1'b1;
               w_burst_nxt = BW'(1);
            end else begin
               w_state_nxt = S_CPU;
               w_burst_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = S_CPU;
            w_burst_nxt = '0;
         end
      endcase
   end

   always_comb begin
      w_starve_nxt = '0;
      if (bus.dma_req && !w_dma_grant) begin
         w_starve_nxt = (r_starve_cnt == C_STARVE_MAX) ? r_starve_cnt : r_starve_cnt + 1'b1;
      end
   end

   // Outputs are masked while reset is low; the flops are held by the async clear.
   assign w_cpu_issue = w_cpu_grant & reset;
   assign w_dma_issue = w_dma_grant & reset;

   always_comb begin
      bus.ram_ldst  = C_IDLE;
      bus.ram_addr  = '0;
      bus.ram_wdata = '0;
      if (w_cpu_issue) begin
         bus.ram_ldst = bus.cpu_we ? C_STORE : C_LOAD;
         bus.ram_addr = bus.cpu_addr;
         if (bus.cpu_we) bus.ram_wdata = bus.cpu_wdata;
      end else if (w_dma_issue) begin
         bus.ram_ldst = bus.dma_we ? C_STORE : C_LOAD;
         bus.ram_addr = bus.dma_addr;
         if (bus.dma_we) bus.ram_wdata = bus.dma_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_CPU;
         r_burst_cnt  <= '0;
         r_starve_cnt <= '0;
         r_tag_valid  <= 1'b0;
         r_tag_dma    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_burst_cnt  <= w_burst_nxt;
         r_starve_cnt <= w_starve_nxt;
         r_tag_valid  <= (w_cpu_grant & ~bus.cpu_we) | (w_dma_grant & ~bus.dma_we);
         r_tag_dma    <= w_dma_grant;
      end
   end

   assign bus.cpu_stall  = bus.cpu_req & ~w_cpu_issue;
   assign bus.dma_gnt    = w_dma_issue;
   assign bus.cpu_rvalid = r_tag_valid & ~r_tag_dma;
   assign bus.dma_rvalid = r_tag_valid & r_tag_dma;
   assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.ram_rdata : '0;
   assign bus.dma_rdata  = bus.dma_rvalid ? bus.ram_rdata : '0;
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ==== tb_mem_port_arbiter : scoreboard bench for mem_port_arbiter ==== rev 1.0 ====
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter_if #(.DW(10), .AW(10)) bus ();

   mem_port_arbiter #(.DW(10), .AW(10), .BURST_MAX(4), .STARVE_MAX(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      int         cyc;
      logic [1:0] ldst;
      logic [9:0] addr;
      logic [9:0] wdata;
      logic       dma;
      logic       stall;
   } cmd_t;

   typedef struct packed {
      int         cyc;
      logic       dma;
      logic [9:0] data;
   } rd_t;

   cmd_t cmd_q[$];
   rd_t  rd_q[$];

   // RAM with one-cycle read latency; preload happens on the first edge (reset is low then)
   logic [9:0] mem [0:1023];
   always @(posedge clk) begin
      if (cyc == 0) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 10'h000;
         mem[10'h005] <= 10'h2A3;
         mem[10'h010] <= 10'h111;
         mem[10'h020] <= 10'h220;
         mem[10'h021] <= 10'h221;
         mem[10'h022] <= 10'h222;
         mem[10'h023] <= 10'h223;
         mem[10'h024] <= 10'h224;
      end else if (bus.ram_ldst == 2'b01) begin
         bus.ram_rdata <= mem[bus.ram_addr];
      end else if (bus.ram_ldst == 2'b10) begin
         mem[bus.ram_addr] <= bus.ram_wdata;
      end
   end

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endfunction

   // Monitor: pops an expectation whenever the DUT issues a RAM command or returns read data
   always @(negedge clk) begin
      cmd_t c;
      rd_t  r;
      if (bus.ram_ldst != 2'b00) begin
         if (cmd_q.size() == 0) begin
            check("cmd_unexpected", 32'(bus.ram_ldst), 32'd0);
         end else begin
            c = cmd_q.pop_front();
            check("cmd_cyc",   cyc, c.cyc);
            check("ram_ldst",  32'(bus.ram_ldst), 32'(c.ldst));
            check("ram_addr",  32'(bus.ram_addr), 32'(c.addr));
            check("ram_wdata", 32'(bus.ram_wdata), 32'(c.wdata));
            check("dma_gnt",   32'(bus.dma_gnt), 32'(c.dma));
            check("cpu_stall", 32'(bus.cpu_stall), 32'(c.stall));
         end
      end
      check("rvalid_both", 32'(bus.cpu_rvalid & bus.dma_rvalid), 32'd0);
      if (bus.cpu_rvalid || bus.dma_rvalid) begin
         if (rd_q.size() == 0) begin
            check("rd_unexpected", 32'({bus.cpu_rvalid, bus.dma_rvalid}), 32'd0);
         end else begin
            r = rd_q.pop_front();
            check("rd_cyc",   cyc, r.cyc);
            check("rd_owner", 32'(bus.dma_rvalid), 32'(r.dma));
            check("rd_data",  32'(r.dma ? bus.dma_rdata : bus.cpu_rdata), 32'(r.data));
         end
      end
      if (!bus.cpu_rvalid) check("cpu_rdata_zero", 32'(bus.cpu_rdata), 32'd0);
      if (!bus.dma_rvalid) check("dma_rdata_zero", 32'(bus.dma_rdata), 32'd0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_set(input logic req, input logic we, input logic [9:0] a, input logic [9:0] d);
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
   endtask

   task automatic dma_set(input logic req, input logic we, input logic [9:0] a, input logic [9:0] d);
      bus.dma_req = req; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
   endtask

   task automatic exp_cmd(input logic dma, input logic we, input logic [9:0] a,
                          input logic [9:0] d, input logic stall);
      cmd_t c;
      c.cyc   = cyc;
      c.ldst  = we ? 2'b10 : 2'b01;
      c.addr  = a;
      c.wdata = we ? d : 10'h000;
      c.dma   = dma;
      c.stall = stall;
      cmd_q.push_back(c);
   endtask

   task automatic exp_rd(input logic dma, input logic [9:0] data);
      rd_t r;
      r.cyc  = cyc + 1;
      r.dma  = dma;
      r.data = data;
      rd_q.push_back(r);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no end of stimulus, expected finish within 100000 ns");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      bus.ram_rdata = 10'h000;
      cpu_set(1'b1, 1'b0, 10'h005, 10'h000);
      dma_set(1'b1, 1'b1, 10'h100, 10'h3FF);
      repeat (3) tick();
      @(negedge clk);
      check("rst_ram_ldst",  32'(bus.ram_ldst), 32'd0);
      check("rst_dma_gnt",   32'(bus.dma_gnt), 32'd0);
      check("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
      tick();

      // CPU-only load right after release
      reset = 1'b1;
      dma_set(1'b0, 1'b0, 10'h000, 10'h000);
      exp_cmd(1'b0, 1'b0, 10'h005, 10'h000, 1'b0); exp_rd(1'b0, 10'h2A3);
      tick();
      cpu_set(1'b0, 1'b0, 10'h000, 10'h000);
      tick();

      // DMA-only store stream, no gaps across the burst boundary
      for (int i = 0; i < 6; i++) begin
         dma_set(1'b1, 1'b1, 10'h100 + 10'(i), 10'h300 + 10'(i));
         exp_cmd(1'b1, 1'b1, 10'h100 + 10'(i), 10'h300 + 10'(i), 1'b0);
         tick();
      end
      dma_set(1'b1, 1'b0, 10'h100, 10'h000);
      exp_cmd(1'b1, 1'b0, 10'h100, 10'h000, 1'b0); exp_rd(1'b1, 10'h300);
      tick();
      dma_set(1'b1, 1'b0, 10'h105, 10'h000);
      exp_cmd(1'b1, 1'b0, 10'h105, 10'h000, 1'b0); exp_rd(1'b1, 10'h305);
      tick();
      dma_set(1'b0, 1'b0, 10'h000, 10'h000);
      cpu_set(1'b1, 1'b0, 10'h103, 10'h000);
      exp_cmd(1'b0, 1'b0, 10'h103, 10'h000, 1'b0); exp_rd(1'b0, 10'h303);
      tick();
      cpu_set(1'b0, 1'b0, 10'h000, 10'h000);
      repeat (2) tick();

      // Contention: 8 CPU grants, 4 forced DMA loads, then CPU again
      dma_set(1'b1, 1'b0, 10'h020, 10'h000);
      for (int k = 0; k < 7; k++) begin
         cpu_set(1'b1, 1'b1, 10'h040 + 10'(k), 10'h0A0 + 10'(k));
         exp_cmd(1'b0, 1'b1, 10'h040 + 10'(k), 10'h0A0 + 10'(k), 1'b0);
         tick();
      end
      cpu_set(1'b1, 1'b0, 10'h010, 10'h000);
      exp_cmd(1'b0, 1'b0, 10'h010, 10'h000, 1'b0); exp_rd(1'b0, 10'h111);
      tick();
      cpu_set(1'b1, 1'b0, 10'h044, 10'h000);
      for (int j = 0; j < 4; j++) begin
         dma_set(1'b1, 1'b0, 10'h020 + 10'(j), 10'h000);
         exp_cmd(1'b1, 1'b0, 10'h020 + 10'(j), 10'h000, 1'b1); exp_rd(1'b1, 10'h220 + 10'(j));
         tick();
      end
      dma_set(1'b1, 1'b0, 10'h024, 10'h000);
      exp_cmd(1'b0, 1'b0, 10'h044, 10'h000, 1'b0); exp_rd(1'b0, 10'h0A4);
      tick();
      cpu_set(1'b0, 1'b0, 10'h000, 10'h000);
      exp_cmd(1'b1, 1'b0, 10'h024, 10'h000, 1'b0); exp_rd(1'b1, 10'h224);
      tick();
      dma_set(1'b0, 1'b0, 10'h000, 10'h000);
      tick();

      // Burst cut: DMA drops after 2 grants, CPU takes over with a cleared starve count
      dma_set(1'b1, 1'b1, 10'h050, 10'h155);
      exp_cmd(1'b1, 1'b1, 10'h050, 10'h155, 1'b0);
      tick();
      cpu_set(1'b1, 1'b0, 10'h050, 10'h000);
      dma_set(1'b1, 1'b1, 10'h051, 10'h156);
      exp_cmd(1'b1, 1'b1, 10'h051, 10'h156, 1'b1);
      tick();
      dma_set(1'b0, 1'b0, 10'h000, 10'h000);
      exp_cmd(1'b0, 1'b0, 10'h050, 10'h000, 1'b0); exp_rd(1'b0, 10'h155);
      tick();
      dma_set(1'b1, 1'b0, 10'h051, 10'h000);
      for (int k = 0; k < 8; k++) begin
         cpu_set(1'b1, 1'b1, 10'h060 + 10'(k), 10'h0C0 + 10'(k));
         exp_cmd(1'b0, 1'b1, 10'h060 + 10'(k), 10'h0C0 + 10'(k), 1'b0);
         tick();
      end
      cpu_set(1'b1, 1'b0, 10'h060, 10'h000);
      exp_cmd(1'b1, 1'b0, 10'h051, 10'h000, 1'b1); exp_rd(1'b1, 10'h156);
      tick();
      dma_set(1'b0, 1'b0, 10'h000, 10'h000);
      exp_cmd(1'b0, 1'b0, 10'h060, 10'h000, 1'b0); exp_rd(1'b0, 10'h0C0);
      tick();
      cpu_set(1'b0, 1'b0, 10'h000, 10'h000);
      repeat (2) tick();

      // Reset pulse while a DMA load is outstanding
      dma_set(1'b1, 1'b0, 10'h020, 10'h000);
      exp_cmd(1'b1, 1'b0, 10'h020, 10'h000, 1'b0);
      tick();
      reset = 1'b0;
      cpu_set(1'b1, 1'b0, 10'h005, 10'h000);
      dma_set(1'b1, 1'b0, 10'h021, 10'h000);
      @(negedge clk);
      check("rst_mid_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
      check("rst_mid_dma_rdata",  32'(bus.dma_rdata), 32'd0);
      check("rst_mid_ram_ldst",   32'(bus.ram_ldst), 32'd0);
      tick();
      tick();
      reset = 1'b1;
      exp_cmd(1'b0, 1'b0, 10'h005, 10'h000, 1'b0); exp_rd(1'b0, 10'h2A3);
      tick();
      cpu_set(1'b0, 1'b0, 10'h000, 10'h000);
      exp_cmd(1'b1, 1'b0, 10'h021, 10'h000, 1'b0); exp_rd(1'b1, 10'h221);
      tick();
      dma_set(1'b0, 1'b0, 10'h000, 10'h000);
      repeat (3) tick();

      check("cmd_q_drained", cmd_q.size(), 32'd0);
      check("rd_q_drained",  rd_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
